// File: rtl/cga_alu_qreg_if.sv
// cga_alu_qreg_if: bus bundle between the microcode/ALU datapath and the Q register.
//   master : drives F_15_0, QLOAD, QSHIFT, QDIR, QSIN_L, QSIN_R, STEP_START, STEP_N_4_0
//            and observes Q_15_0, QSOUT_L, QSOUT_R, STEP_BUSY, STEP_DONE, STEP_CNT_4_0.
//   slave  : the Q register stage (directions mirrored).
// Optional macro CGA_ALU_QREG_PAR_EN adds the QPAR parity signal.
interface cga_alu_qreg_if;
  logic [15:0] F_15_0;
  logic        QLOAD;
  logic        QSHIFT;
  logic        QDIR;
  logic        QSIN_L;
  logic        QSIN_R;
  logic        STEP_START;
  logic [4:0]  STEP_N_4_0;
  logic [15:0] Q_15_0;
  logic        QSOUT_L;
  logic        QSOUT_R;
  logic        STEP_BUSY;
  logic        STEP_DONE;
  logic [4:0]  STEP_CNT_4_0;
`ifdef CGA_ALU_QREG_PAR_EN
  logic        QPAR;
`endif

  modport master (
`ifdef CGA_ALU_QREG_PAR_EN
    input  QPAR,
`endif
    output F_15_0, QLOAD, QSHIFT, QDIR, QSIN_L, QSIN_R, STEP_START, STEP_N_4_0,
    input  Q_15_0, QSOUT_L, QSOUT_R, STEP_BUSY, STEP_DONE, STEP_CNT_4_0
  );

  modport slave (
`ifdef CGA_ALU_QREG_PAR_EN
    output QPAR,
`endif
    input  F_15_0, QLOAD, QSHIFT, QDIR, QSIN_L, QSIN_R, STEP_START, STEP_N_4_0,
    output Q_15_0, QSOUT_L, QSOUT_R, STEP_BUSY, STEP_DONE, STEP_CNT_4_0
  );
endinterface

// File: rtl/cga_alu_qreg.sv
// cga_alu_qreg: 16-bit Q operand register for the CGA ALU with load, single
// shift and an autonomous N-step shift sequencer (IDLE -> RUN -> DONE).
// Ports:
//   sysclk   - system clock, rising edge
//   sys_rst  - synchronous active-high reset
//   bus      - cga_alu_qreg_if.slave: load/shift controls, step controls,
//              Q_15_0 register output, shift-out bits, step status
// Optional feature: define CGA_ALU_QREG_PAR_EN to add the registered even
// parity output QPAR (Q_15_0 ^ QPAR reduces to 0).
module cga_alu_qreg (
  input logic           sysclk,
  input logic           sys_rst,
  cga_alu_qreg_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t      state_r, state_nx_s;
  logic [15:0] q_r, q_nx_s;
  logic        dir_r, dir_nx_s;
  logic [4:0]  cnt_r, cnt_nx_s;
  logic        busy_r;
  logic        done_r;

  // One-bit shift: dir 0 = left (fill bit 0), dir 1 = right (fill bit 15).
  function automatic logic [15:0] shift_q(input logic [15:0] q, input logic dir,
                                          input logic sin_l, input logic sin_r);
    if (dir == 1'b0) begin
      return {q[14:0], sin_l};
    end else begin
      return {sin_r, q[15:1]};
    end
  endfunction

  // Step count 0 means a full 16; anything beyond 16 saturates at 16.
  function automatic logic [4:0] norm_n(input logic [4:0] n);
    if ((n == 5'd0) || (n > 5'd16)) begin
      return 5'd16;
    end else begin
      return n;
    end
  endfunction

`ifdef CGA_ALU_QREG_PAR_EN
  // Even parity: the returned bit makes the total count of ones even.
  function automatic logic even_par(input logic [15:0] q);
    return ^q;
  endfunction
`endif

  // Next-state, next-Q and counter decode for the step sequencer.
  always_comb begin
    state_nx_s = state_r;
    q_nx_s     = q_r;
    dir_nx_s   = dir_r;
    cnt_nx_s   = cnt_r;
    case (state_r)
      ST_IDLE, ST_DONE: begin
        if (bus.QLOAD) begin
          q_nx_s = bus.F_15_0;
        end else if (bus.QSHIFT) begin
          q_nx_s = shift_q(q_r, bus.QDIR, bus.QSIN_L, bus.QSIN_R);
        end else begin
          q_nx_s = q_r;
        end
        if (bus.STEP_START) begin
          dir_nx_s   = bus.QDIR;
          cnt_nx_s   = norm_n(bus.STEP_N_4_0);
          state_nx_s = ST_RUN;
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        // A load replaces this cycle's shift but still consumes a step.
        if (bus.QLOAD) begin
          q_nx_s = bus.F_15_0;
        end else begin
          q_nx_s = shift_q(q_r, dir_r, bus.QSIN_L, bus.QSIN_R);
        end
        cnt_nx_s = cnt_r - 5'd1;
        if (cnt_r == 5'd1) begin
          state_nx_s = ST_DONE;
        end else begin
          state_nx_s = ST_RUN;
        end
      end
      default: begin
        state_nx_s = ST_IDLE;
        cnt_nx_s   = 5'd0;
      end
    endcase
  end

  // State, Q and status registers; status flags are registered from the next state.
  always_ff @(posedge sysclk) begin
    if (sys_rst) begin
      state_r <= ST_IDLE;
      q_r     <= 16'h0000;
      dir_r   <= 1'b0;
      cnt_r   <= 5'd0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_nx_s;
      q_r     <= q_nx_s;
      dir_r   <= dir_nx_s;
      cnt_r   <= cnt_nx_s;
      busy_r  <= (state_nx_s == ST_RUN);
      done_r  <= (state_nx_s == ST_DONE);
    end
  end

`ifdef CGA_ALU_QREG_PAR_EN
  logic par_r;

  // Parity register tracks the same next value that Q is loaded with.
  always_ff @(posedge sysclk) begin
    if (sys_rst) begin
      par_r <= 1'b0;
    end else begin
      par_r <= even_par(q_nx_s);
    end
  end

  assign bus.QPAR = par_r;
`endif

  assign bus.Q_15_0       = q_r;
  assign bus.QSOUT_L      = q_r[15];
  assign bus.QSOUT_R      = q_r[0];
  assign bus.STEP_BUSY    = busy_r;
  assign bus.STEP_DONE    = done_r;
  assign bus.STEP_CNT_4_0 = cnt_r;

endmodule

// File: tb/tb_cga_alu_qreg.sv
// tb_cga_alu_qreg: directed self-checking bench for cga_alu_qreg.
// Inputs change 1 time unit after each rising edge; outputs are checked there too.
module tb_cga_alu_qreg;

  logic sysclk;
  logic sys_rst;
  int   total;
  int   bad;

  cga_alu_qreg_if qif ();

  cga_alu_qreg dut (
    .sysclk  (sysclk),
    .sys_rst (sys_rst),
    .bus     (qif)
  );

  initial sysclk = 1'b0;
  always #5 sysclk = ~sysclk;

  task automatic tick();
    @(posedge sysclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    qif.F_15_0     = 16'h0000;
    qif.QLOAD      = 1'b0;
    qif.QSHIFT     = 1'b0;
    qif.QDIR       = 1'b0;
    qif.QSIN_L     = 1'b0;
    qif.QSIN_R     = 1'b0;
    qif.STEP_START = 1'b0;
    qif.STEP_N_4_0 = 5'd0;
  endtask

  task automatic rand_inputs();
    qif.F_15_0     = 16'($urandom);
    qif.QLOAD      = 1'($urandom);
    qif.QSHIFT     = 1'($urandom);
    qif.QDIR       = 1'($urandom);
    qif.QSIN_L     = 1'($urandom);
    qif.QSIN_R     = 1'($urandom);
    qif.STEP_START = 1'($urandom);
    qif.STEP_N_4_0 = 5'($urandom);
  endtask

  task automatic chk_status(input string tag, input logic busy, input logic done,
                            input logic [4:0] cnt);
    chk({tag, "_busy"}, {15'd0, qif.STEP_BUSY}, {15'd0, busy});
    chk({tag, "_done"}, {15'd0, qif.STEP_DONE}, {15'd0, done});
    chk({tag, "_cnt"}, {11'd0, qif.STEP_CNT_4_0}, {11'd0, cnt});
  endtask

  logic [15:0] seq_q [4];

  initial begin
    total = 0;
    bad   = 0;
    seq_q = '{16'h7800, 16'h3C00, 16'h1E00, 16'h0F00};

    // Reset after random activity
    clear_inputs();
    sys_rst = 1'b1;
    repeat (3) tick();
    sys_rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      rand_inputs();
      tick();
    end
    rand_inputs();
    sys_rst = 1'b1;
    tick();
    chk("rst_q", qif.Q_15_0, 16'h0000);
    chk_status("rst", 1'b0, 1'b0, 5'd0);
    sys_rst = 1'b0;
    clear_inputs();

    // Load then single shifts
    qif.QLOAD  = 1'b1;
    qif.F_15_0 = 16'h8001;
    tick();
    chk("load_q", qif.Q_15_0, 16'h8001);
    chk("load_soutl", {15'd0, qif.QSOUT_L}, 16'h0001);
    chk("load_soutr", {15'd0, qif.QSOUT_R}, 16'h0001);
    qif.QLOAD  = 1'b0;
    qif.QSHIFT = 1'b1;
    qif.QDIR   = 1'b0;
    qif.QSIN_L = 1'b1;
    tick();
    chk("shl_q", qif.Q_15_0, 16'h0003);
    chk("shl_soutl", {15'd0, qif.QSOUT_L}, 16'h0000);
    qif.QDIR   = 1'b1;
    qif.QSIN_R = 1'b1;
    tick();
    chk("shr_q", qif.Q_15_0, 16'h8001);
    clear_inputs();

    // N=4 right sequence from F000, fill 0
    qif.QLOAD  = 1'b1;
    qif.F_15_0 = 16'hF000;
    tick();
    qif.QLOAD      = 1'b0;
    qif.STEP_START = 1'b1;
    qif.STEP_N_4_0 = 5'd4;
    qif.QDIR       = 1'b1;
    tick();
    chk("seq_start_q", qif.Q_15_0, 16'hF000);
    chk_status("seq_start", 1'b1, 1'b0, 5'd4);
    qif.STEP_START = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("seq_q%0d", i), qif.Q_15_0, seq_q[i]);
      chk_status($sformatf("seq%0d", i), (i < 3), (i == 3), 5'(3 - i));
    end
    tick();
    chk("seq_after_q", qif.Q_15_0, 16'h0F00);
    chk_status("seq_after", 1'b0, 1'b0, 5'd0);

    // N=0 -> 16 left shifts; QSHIFT/QDIR/STEP_START during RUN ignored
    qif.QLOAD  = 1'b1;
    qif.F_15_0 = 16'hA5A5;
    tick();
    qif.QLOAD      = 1'b0;
    qif.STEP_START = 1'b1;
    qif.STEP_N_4_0 = 5'd0;
    qif.QDIR       = 1'b0;
    qif.QSIN_L     = 1'b1;
    tick();
    chk("n0_start_q", qif.Q_15_0, 16'hA5A5);
    chk_status("n0_start", 1'b1, 1'b0, 5'd16);
    qif.STEP_START = 1'b0;
    qif.QSHIFT     = 1'b1;
    qif.QDIR       = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      tick();
      chk_status($sformatf("n0_%0d", i), (i < 16), (i == 16), 5'(16 - i));
      if (i == 8) chk("n0_q8", qif.Q_15_0, 16'hA5FF);
      if (i == 3) begin
        qif.STEP_START = 1'b1;
        qif.STEP_N_4_0 = 5'd2;
      end
      if (i == 6) qif.STEP_START = 1'b0;
    end
    chk("n0_q16", qif.Q_15_0, 16'hFFFF);
    clear_inputs();
    tick();
    chk("n0_after_q", qif.Q_15_0, 16'hFFFF);
    chk_status("n0_after", 1'b0, 1'b0, 5'd0);

    // N=31 saturates to 16 right shifts, then back-to-back start from DONE
    qif.QLOAD  = 1'b1;
    qif.F_15_0 = 16'h1234;
    tick();
    qif.QLOAD      = 1'b0;
    qif.STEP_START = 1'b1;
    qif.STEP_N_4_0 = 5'd31;
    qif.QDIR       = 1'b1;
    qif.QSIN_R     = 1'b1;
    tick();
    chk_status("n31_start", 1'b1, 1'b0, 5'd16);
    qif.STEP_START = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      tick();
      chk_status($sformatf("n31_%0d", i), (i < 16), (i == 16), 5'(16 - i));
      if (i == 15) chk("n31_q15", qif.Q_15_0, 16'hFFFE);
    end
    chk("n31_q16", qif.Q_15_0, 16'hFFFF);
    qif.STEP_START = 1'b1;
    qif.STEP_N_4_0 = 5'd1;
    qif.QDIR       = 1'b0;
    qif.QSIN_L     = 1'b0;
    qif.QSIN_R     = 1'b0;
    tick();
    chk("b2b_start_q", qif.Q_15_0, 16'hFFFF);
    chk_status("b2b_start", 1'b1, 1'b0, 5'd1);
    qif.STEP_START = 1'b0;
    tick();
    chk("b2b_end_q", qif.Q_15_0, 16'hFFFE);
    chk_status("b2b_end", 1'b0, 1'b1, 5'd0);
    tick();
    chk_status("b2b_after", 1'b0, 1'b0, 5'd0);

    // Load override on 2nd RUN cycle of an N=3 left sequence
    clear_inputs();
    qif.QLOAD  = 1'b1;
    qif.F_15_0 = 16'h00FF;
    tick();
    qif.QLOAD      = 1'b0;
    qif.STEP_START = 1'b1;
    qif.STEP_N_4_0 = 5'd3;
    qif.QDIR       = 1'b0;
    tick();
    chk_status("ovr_start", 1'b1, 1'b0, 5'd3);
    qif.STEP_START = 1'b0;
    tick();
    chk("ovr_q1", qif.Q_15_0, 16'h01FE);
    qif.QLOAD  = 1'b1;
    qif.F_15_0 = 16'h1234;
    tick();
    chk("ovr_q2", qif.Q_15_0, 16'h1234);
    chk_status("ovr2", 1'b1, 1'b0, 5'd1);
    qif.QLOAD = 1'b0;
    tick();
    chk("ovr_q3", qif.Q_15_0, 16'h2468);
    chk_status("ovr3", 1'b0, 1'b1, 5'd0);
    tick();

    // Reset during RUN: immediate IDLE and no DONE pulse
    qif.QLOAD  = 1'b1;
    qif.F_15_0 = 16'hBEEF;
    tick();
    qif.QLOAD      = 1'b0;
    qif.STEP_START = 1'b1;
    qif.STEP_N_4_0 = 5'd5;
    qif.QDIR       = 1'b1;
    tick();
    qif.STEP_START = 1'b0;
    tick();
    chk("mid_q1", qif.Q_15_0, 16'h5F77);
    sys_rst = 1'b1;
    tick();
    chk("mid_rst_q", qif.Q_15_0, 16'h0000);
    chk_status("mid_rst", 1'b0, 1'b0, 5'd0);
    sys_rst = 1'b0;
    tick();
    chk_status("mid_after", 1'b0, 1'b0, 5'd0);
    tick();
    chk_status("mid_after2", 1'b0, 1'b0, 5'd0);

`ifdef CGA_ALU_QREG_PAR_EN
    // Parity invariant over random traffic
    for (int i = 0; i < 1000; i++) begin
      rand_inputs();
      sys_rst = ($urandom_range(0, 99) == 0);
      tick();
      chk("parity", {15'd0, ^{qif.Q_15_0, qif.QPAR}}, 16'h0000);
    end
    sys_rst = 1'b0;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cga_alu_qreg.md
# cga_alu_qreg

Q register stage for the CGA ALU: a 16-bit register holding the Q operand supplied directly to the ALU source-operand multiplexer. It loads from the ALU result bus, shifts left or right by one bit under microcode control, and contains a small step sequencer that performs an autonomous N-cycle shift sequence for iterative multiply and divide microinstructions. Q_15_0 is registered, so operand selection downstream always sees a stable, glitch-free value.

## Interface
- No parameters; width is fixed at 16 bits, and the step count field is 5 bits.
- sysclk  in  1  system clock; all state changes on the rising edge
- sys_rst  in  1  reset; synchronous, active-high
- F_15_0  in  16  ALU result bus; load source
- QLOAD  in  1  load Q from F_15_0
- QSHIFT  in  1  single microcode-driven shift; ignored while STEP_BUSY=1
- QDIR  in  1  shift direction: 0 = left (toward bit 15), 1 = right
- QSIN_L  in  1  bit entering Q[0] on a left shift
- QSIN_R  in  1  bit entering Q[15] on a right shift
- STEP_START  in  1  start an autonomous shift sequence
- STEP_N_4_0  in  5  sequence length; valid values 1..16; 0 is treated as 16; values 17..31 are saturated to 16
- Q_15_0  out  16  registered Q contents; feeds the S-operand multiplexer
- QSOUT_L  out  1  Q[15]; the bit shifted out on a left shift (combinational from the register)
- QSOUT_R  out  1  Q[0]; the bit shifted out on a right shift
- STEP_BUSY  out  1  a sequence is in progress
- STEP_DONE  out  1  one-cycle pulse when a sequence completes
- STEP_CNT_4_0  out  5  number of shifts remaining in the current sequence
- QPAR  out  1  present only with CGA_ALU_QREG_PAR_EN; see Configuration

## Operation
- State machine: IDLE, RUN, DONE.
- IDLE:
  - QLOAD=1: Q <= F_15_0.
  - Otherwise, QSHIFT=1: Q shifts one bit in direction QDIR.
  - Otherwise, Q holds its value.
  - STEP_START=1: latch the direction from QDIR, set STEP_CNT to the normalised STEP_N, and go to RUN. In that same cycle, QLOAD and QSHIFT still act as described above.
- RUN, on every cycle:
  - Shift Q one bit in the latched direction, using the live QSIN_L or QSIN_R input of that cycle.
  - Decrement STEP_CNT.
  - When STEP_CNT goes from 1 to 0, go to DONE.
- RUN, input handling:
  - QLOAD=1 overrides that cycle's shift: Q <= F_15_0. The counter still decrements, so the sequence is not extended.
  - QSHIFT and STEP_START are ignored.
- DONE: lasts exactly one cycle with STEP_DONE=1, then returns to IDLE. DONE behaves like IDLE for QLOAD, QSHIFT and STEP_START, so a new sequence can start back-to-back.
- Shift definitions:
  - Left: Q <= {Q[14:0], QSIN_L}.
  - Right: Q <= {QSIN_R, Q[15:1]}.

## Timing
- Reset values: Q_15_0=16'h0000, STEP_BUSY=0, STEP_DONE=0, STEP_CNT_4_0=0, state IDLE.
- Reset always wins, including mid-sequence; there is no DONE pulse after a reset.
- Load and shift latency: one edge. The new Q is visible on Q_15_0 in the cycle after the command.
- Sequence timeline, with STEP_START sampled at edge k:
  - Edge k: STEP_BUSY=1 and STEP_CNT=N, both visible after edge k.
  - Edges k+1..k+N: the N shifts occur.
  - Edge k+N: STEP_BUSY=0 and STEP_DONE=1.
  - Edge k+N+1: STEP_DONE=0.
- STEP_CNT_4_0 reads N, N-1, …, 1 during RUN and 0 in DONE.
- QSOUT_L/QSOUT_R reflect the current register. Microcode samples them in the same cycle a shift is issued to capture the departing bit.

## Configuration
- CGA_ALU_QREG_PAR_EN defined:
  - QPAR port exists.
  - QPAR is a registered even-parity bit of Q, updated on the same edge as Q, so that XOR(Q_15_0, QPAR)=0 at all times.
  - Reset value of QPAR is 0.
- Not defined: the QPAR port and its logic are absent; all other behaviour is identical.

## Test plan
- Reset: run several cycles with random inputs, then assert sys_rst for one edge -> Q=0000, BUSY=0, DONE=0, CNT=0.
- Load then shift: QLOAD with F=16'h8001, then QSHIFT with QDIR=0 and QSIN_L=1 -> Q=0003. Then QDIR=1 with QSIN_R=1 -> Q=8001.
- Sequence: Q=16'hF000, STEP_START with N=4, QDIR=1, QSIN_R held at 0 -> BUSY high for 4 cycles, CNT 4,3,2,1, then Q=0F00 with DONE pulsed once.
- Boundaries: STEP_N=0 -> 16 shifts. STEP_N=31 -> 16 shifts. STEP_START raised during RUN -> ignored. STEP_START raised in the DONE cycle -> new sequence starts.
- Override: QLOAD with F=1234 on the 2nd RUN cycle of an N=3 left sequence with QSIN_L=0 -> Q=1234 after that edge, then Q=2468 after the final shift. DONE is still asserted at edge k+3.
- Reset mid-sequence at the 2nd RUN cycle -> immediate IDLE, no DONE pulse. With CGA_ALU_QREG_PAR_EN, check QPAR parity invariant over 1000 random cycles.
